// File: rtl/ahb_slave_regfile.sv
// ----------------------------------------------------------------------------
// ahb_slave_regfile
//
// AHB-Lite responder holding NUM_REGS 32-bit registers. Each data phase
// takes WAIT_CYCLES+1 cycles. The slave accepts byte, halfword and word
// writes and always returns a full word on reads.
//
// Optional feature macro: AHB_SLV_ERR_EN
//   When defined, the following accesses are illegal and take the two-cycle
//   ERROR response: an out-of-range index, a size above word, or a misaligned
//   half or word access. Illegal accesses leave the registers unchanged.
//   When undefined, the error states are not built. Out-of-range reads
//   return 0 and out-of-range writes are ignored. A size above word is
//   treated as a word, and misaligned accesses use the lane rules with the
//   low address bits masked.
//
// Parameters:
//   NUM_REGS     number of registers (1..2**ADDR_W)
//   ADDR_W       word-index width, index = sl_HADDR[ADDR_W+1:2]
//   WAIT_CYCLES  wait states inserted per data phase (0..15)
//
// Ports:
//   HCLK           clock, rising edge
//   HRESET         synchronous active-high reset
//   sl_HSEL        slave select from the address decoder
//   sl_HREADY      bus-level HREADY (muxed response of the active slave)
//   sl_HTRANS      IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   sl_HBURST      burst type (ignored)
//   sl_HSIZE       0=byte, 1=half, 2=word
//   sl_HADDR       byte address
//   sl_HWRITE      1=write
//   sl_HWDATA      write data (data phase)
//   out_sl_HREADY  slave ready
//   out_sl_HRESP   OKAY=00, ERROR=01
//   out_sl_HRDATA  read data
// ----------------------------------------------------------------------------
module ahb_slave_regfile #(
    parameter int NUM_REGS    = 12,
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        sl_HSEL,
    input  logic        sl_HREADY,
    input  logic [1:0]  sl_HTRANS,
    input  logic [2:0]  sl_HBURST,
    input  logic [2:0]  sl_HSIZE,
    input  logic [31:0] sl_HADDR,
    input  logic        sl_HWRITE,
    input  logic [31:0] sl_HWDATA,
    output logic        out_sl_HREADY,
    output logic [1:0]  out_sl_HRESP,
    output logic [31:0] out_sl_HRDATA
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
`ifdef AHB_SLV_ERR_EN
        S_DATA,
        S_ERR1,
        S_ERR2
`else
        S_DATA
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        low_q, low_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];

    logic              accept;
    logic [ADDR_W-1:0] reqIdx;
    logic [3:0]        laneEn;
    logic [31:0]       readWord;
    state_t            directState;
    state_t            waitExitState;
    logic              unusedBits;

    assign accept = sl_HSEL & sl_HREADY & sl_HTRANS[1];
    assign reqIdx = sl_HADDR[ADDR_W+1:2];

    // The burst type, the BUSY/SEQ distinction and the upper address bits
    // carry no meaning for this slave. Each beat is decoded on its own.
    assign unusedBits = ^{sl_HBURST, sl_HTRANS[0], sl_HADDR[31:ADDR_W+2]};

`ifdef AHB_SLV_ERR_EN
    logic reqIllegal;
    logic illegal_q, illegal_d;

    assign reqIllegal = ({1'b0, reqIdx} >= (ADDR_W+1)'(NUM_REGS))
                        || (sl_HSIZE > 3'd2)
                        || ((sl_HSIZE == 3'd1) && sl_HADDR[0])
                        || ((sl_HSIZE == 3'd2) && (sl_HADDR[1:0] != 2'b00));

    // The illegal verdict is taken at accept and held through any wait
    // states, so the ERROR response starts once the waits have run out.
    assign directState   = reqIllegal ? S_ERR1 : S_DATA;
    assign waitExitState = illegal_q ? S_ERR1 : S_DATA;

    always_comb begin
        illegal_d = illegal_q;
        if (accept && (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2)) begin
            illegal_d = reqIllegal;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign directState   = S_DATA;
    assign waitExitState = S_DATA;
`endif

    // Little-endian byte lanes. A size above word falls into the word case.
    always_comb begin
        laneEn = 4'b0000;
        case (size_q)
            3'd0:    laneEn = 4'b0001 << low_q;
            3'd1:    laneEn = low_q[1] ? 4'b1100 : 4'b0011;
            default: laneEn = 4'b1111;
        endcase
    end

    // Indexes with no backing register read as zero.
    always_comb begin
        readWord = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == ADDR_W'(i)) begin
                readWord = regs_q[i];
            end
        end
    end

    // Write data arrives during the data phase, so it is committed at the
    // edge that ends S_DATA. A read pipelined right behind it sees the new
    // value. Out-of-range indexes match no register, so the write is lost.
    always_comb begin
        regs_d = regs_q;
        if (state_q == S_DATA && write_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == ADDR_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (laneEn[b]) begin
                            regs_d[i][8*b +: 8] = sl_HWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Next state and bus outputs. The states that end a data phase
    // (IDLE, DATA, ERR2) can also open the next one. This keeps pipelined
    // transfers going at one per WAIT_CYCLES+1 cycles.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        low_d         = low_q;
        size_d        = size_q;
        write_d       = write_q;
        out_sl_HREADY = 1'b1;
        out_sl_HRESP  = RESP_OKAY;
        out_sl_HRDATA = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_WAIT: begin
                out_sl_HREADY = 1'b0;
                cnt_d         = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = waitExitState;
                end
            end
            S_DATA: begin
                state_d = S_IDLE;
                if (!write_q) begin
                    out_sl_HRDATA = readWord;
                end
            end
`ifdef AHB_SLV_ERR_EN
            S_ERR1: begin
                out_sl_HREADY = 1'b0;
                out_sl_HRESP  = RESP_ERROR;
                state_d       = S_ERR2;
            end
            S_ERR2: begin
                out_sl_HRESP = RESP_ERROR;
                state_d      = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept && (state_q != S_WAIT)
`ifdef AHB_SLV_ERR_EN
            && (state_q != S_ERR1)
`endif
            ) begin
            idx_d   = reqIdx;
            low_d   = sl_HADDR[1:0];
            size_d  = sl_HSIZE;
            write_d = sl_HWRITE;
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = (WAIT_CYCLES > 0) ? S_WAIT : directState;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            low_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            low_q   <= low_d;
            size_q  <= size_d;
            write_q <= write_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_regfile
//
// Three instances of ahb_slave_regfile share one AHB master. They use
// WAIT_CYCLES of 0, 1 and 2, and only the active instance is selected.
// A pipelined master feeds each instance a queue of transfers. Every
// completed data phase is compared against a per-instance register model.
// The model is built from byte-lane rules and address arithmetic.
// ----------------------------------------------------------------------------
module tb_ahb_slave_regfile;

    localparam int NUM_DUTS = 3;
    localparam int NUM_REGS = 12;
    localparam int ADDR_W   = 4;
    localparam int BUDGET   = 3000;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hselBus;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    int          activeDut;

    logic        selVec   [NUM_DUTS];
    logic        readyVec [NUM_DUTS];
    logic [1:0]  respVec  [NUM_DUTS];
    logic [31:0] rdataVec [NUM_DUTS];

    logic [31:0] model [NUM_DUTS][16];
    xfer_t       stimQ [$];

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_DUTS; g++) begin : gDut
        assign selVec[g] = hselBus && (activeDut == g);

        ahb_slave_regfile #(
            .NUM_REGS   (NUM_REGS),
            .ADDR_W     (ADDR_W),
            .WAIT_CYCLES(g)
        ) uDut (
            .HCLK         (clk),
            .HRESET       (hreset),
            .sl_HSEL      (selVec[g]),
            .sl_HREADY    (readyVec[g]),
            .sl_HTRANS    (htrans),
            .sl_HBURST    (hburst),
            .sl_HSIZE     (hsize),
            .sl_HADDR     (haddr),
            .sl_HWRITE    (hwrite),
            .sl_HWDATA    (hwdata),
            .out_sl_HREADY(readyVec[g]),
            .out_sl_HRESP (respVec[g]),
            .out_sl_HRDATA(rdataVec[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s (dut %0d): observed=0x%08h expected=0x%08h",
                     tag, activeDut, observed, expected);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans,
                                 input logic write, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t t;
        t.sel   = sel;
        t.trans = trans;
        t.burst = 3'd1;
        t.write = write;
        t.size  = size;
        t.addr  = addr;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic int wordIndex(input xfer_t t);
        return int'(t.addr >> 2) % 16;
    endfunction

    function automatic bit isIllegal(input xfer_t t);
`ifdef AHB_SLV_ERR_EN
        return (wordIndex(t) >= NUM_REGS) || (t.size > 3'd2)
               || (t.size == 3'd1 && t.addr % 2 != 0)
               || (t.size == 3'd2 && t.addr % 4 != 0);
`else
        return (t.size > 3'd7);
`endif
    endfunction

    // Bits of the word touched by a write, from the little-endian lane rules.
    function automatic logic [31:0] writeMask(input xfer_t t);
        int offset;
        offset = int'(t.addr % 4);
        if (t.size == 3'd0) begin
            return 32'hFF << (8 * offset);
        end else if (t.size == 3'd1) begin
            return (offset >= 2) ? 32'hFFFF_0000 : 32'h0000_FFFF;
        end
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] expectedRead(input int dut, input xfer_t t);
        if (wordIndex(t) >= NUM_REGS) begin
            return 32'h0;
        end
        return model[dut][wordIndex(t)];
    endfunction

    task automatic applyModelWrite(input int dut, input xfer_t t);
        logic [31:0] m;
        if (wordIndex(t) < NUM_REGS) begin
            m = writeMask(t);
            model[dut][wordIndex(t)] = (model[dut][wordIndex(t)] & ~m) | (t.wdata & m);
        end
    endtask

    task automatic driveAddr(input xfer_t t);
        hselBus = t.sel;
        htrans  = t.trans;
        hburst  = t.burst;
        hwrite  = t.write;
        hsize   = t.size;
        haddr   = t.addr;
    endtask

    task automatic driveIdle();
        hselBus = 1'b0;
        htrans  = 2'b00;
        hburst  = 3'd0;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        haddr   = 32'h0;
        hwdata  = 32'h0;
    endtask

    // Pipelined master: the address phase of the next entry overlaps the
    // data phase of the previous one and advances only while HREADY is high.
    task automatic applyStimulus();
        xfer_t aph, dph;
        bit    aphLive;
        int    dphKind;
        int    waitCount, cycles, expWait;
        bit    err, readyNow;
        aphLive   = 1'b0;
        dphKind   = 0;
        waitCount = 0;
        cycles    = 0;
        if (stimQ.size() > 0) begin
            aph     = stimQ.pop_front();
            aphLive = 1'b1;
        end
        while ((aphLive || dphKind != 0) && cycles < BUDGET) begin
            if (aphLive) driveAddr(aph);
            else         driveIdle();
            hwdata = (dphKind == 2 && dph.write) ? dph.wdata : 32'h0;
            @(negedge clk);
            cycles++;
            readyNow = readyVec[activeDut];
            if (dphKind == 2) begin
                err     = isIllegal(dph);
                expWait = activeDut + (err ? 1 : 0);
                if (!readyNow) begin
                    checkOutput("waitResp", 32'(respVec[activeDut]),
                                (err && waitCount == activeDut) ? 32'h1 : 32'h0);
                    waitCount++;
                end else begin
                    checkOutput("waitCycles", waitCount, expWait);
                    checkOutput("resp", 32'(respVec[activeDut]), err ? 32'h1 : 32'h0);
                    if (!dph.write) begin
                        checkOutput("rdata", rdataVec[activeDut],
                                    err ? 32'h0 : expectedRead(activeDut, dph));
                    end else begin
                        checkOutput("rdataOnWrite", rdataVec[activeDut], 32'h0);
                        if (!err) applyModelWrite(activeDut, dph);
                    end
                end
            end else if (dphKind == 1) begin
                checkOutput("noXferReady", 32'(readyNow), 32'h1);
                checkOutput("noXferResp", 32'(respVec[activeDut]), 32'h0);
            end
            @(posedge clk);
            #1;
            if (readyNow) begin
                waitCount = 0;
                if (aphLive) begin
                    dph     = aph;
                    dphKind = (aph.sel && aph.trans[1]) ? 2 : 1;
                end else begin
                    dphKind = 0;
                end
                if (stimQ.size() > 0) begin
                    aph     = stimQ.pop_front();
                    aphLive = 1'b1;
                end else begin
                    aphLive = 1'b0;
                end
            end
        end
        checkOutput("cycleBudget", 32'(cycles < BUDGET), 32'h1);
        stimQ.delete();
        driveIdle();
    endtask

    task automatic clearModels();
        for (int d = 0; d < NUM_DUTS; d++) begin
            for (int r = 0; r < 16; r++) begin
                model[d][r] = 32'h0;
            end
        end
    endtask

    initial begin
        xfer_t t;
        int    r, idx;
        activeDut = 0;
        driveIdle();
        clearModels();
        hreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NUM_DUTS; d++) begin
            activeDut = d;
            checkOutput("resetReady", 32'(readyVec[d]), 32'h1);
            checkOutput("resetResp", 32'(respVec[d]), 32'h0);
            checkOutput("resetRdata", rdataVec[d], 32'h0);
        end
        @(posedge clk);
        #1;

        $display("[TB] back-to-back write/read, zero wait");
        activeDut = 0;
        stimQ.push_back(mk(1, 2'b10, 1, 3'd2, 32'h08, 32'hDEAD_BEEF));
        stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'h08, 32'h0));
        applyStimulus();

        $display("[TB] write then read with two wait states");
        activeDut = 2;
        stimQ.push_back(mk(1, 2'b10, 1, 3'd2, 32'h04, 32'h1234_5678));
        stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'h04, 32'h0));
        applyStimulus();

        $display("[TB] byte and halfword lanes");
        activeDut = 0;
        stimQ.push_back(mk(1, 2'b10, 1, 3'd0, 32'h0D, 32'h0000_AA00));
        stimQ.push_back(mk(1, 2'b10, 1, 3'd1, 32'h0E, 32'hBEEF_0000));
        stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'h0C, 32'h0));
        applyStimulus();

        $display("[TB] access beyond the register bank");
        stimQ.push_back(mk(1, 2'b10, 1, 3'd2, 32'h30, 32'h5555_AAAA));
        stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'h30, 32'h0));
        stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'h2C, 32'h0));
        applyStimulus();

        $display("[TB] INCR burst with a BUSY beat, one wait state");
        activeDut = 1;
        stimQ.push_back(mk(1, 2'b10, 1, 3'd2, 32'h10, 32'h1111_0001));
        stimQ.push_back(mk(1, 2'b11, 1, 3'd2, 32'h14, 32'h2222_0002));
        stimQ.push_back(mk(1, 2'b01, 1, 3'd2, 32'h18, 32'h0));
        stimQ.push_back(mk(1, 2'b11, 1, 3'd2, 32'h18, 32'h3333_0003));
        stimQ.push_back(mk(1, 2'b11, 1, 3'd2, 32'h1C, 32'h4444_0004));
        for (int a = 16; a < 32; a += 4) begin
            stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'(a), 32'h0));
        end
        applyStimulus();

        $display("[TB] randomized traffic");
        for (int d = 0; d < NUM_DUTS; d++) begin
            activeDut = d;
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                t = mk(1, 2'b10, 1'($urandom_range(0, 1)), 3'd2, 32'h0, $urandom);
                if (r == 0) t.trans = 2'b00;
                if (r == 1) t.trans = 2'b01;
                if (r == 2) t.sel = 1'b0;
                if (r == 3) t.trans = 2'b11;
                t.size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                idx = $urandom_range(0, 15);
                t.addr = 32'(idx * 4);
                if ($urandom_range(0, 3) == 0 || t.size == 3'd0) begin
                    t.addr = t.addr + 32'($urandom_range(0, 3));
                end else if (t.size == 3'd1) begin
                    t.addr = t.addr + 32'(2 * $urandom_range(0, 1));
                end
                stimQ.push_back(t);
            end
            for (int a = 0; a < 64; a += 4) begin
                stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'(a), 32'h0));
            end
            applyStimulus();
        end

        $display("[TB] reset during wait states");
        activeDut = 2;
        stimQ.push_back(mk(1, 2'b10, 1, 3'd2, 32'h00, 32'h0BAD_0BAD));
        applyStimulus();
        driveAddr(mk(1, 2'b10, 1, 3'd2, 32'h00, 32'h0));
        @(posedge clk);
        #1;
        driveIdle();
        hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("inWaitReady", 32'(readyVec[2]), 32'h0);
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        hwdata = 32'h0;
        @(negedge clk);
        checkOutput("postResetReady", 32'(readyVec[2]), 32'h1);
        checkOutput("postResetResp", 32'(respVec[2]), 32'h0);
        checkOutput("postResetRdata", rdataVec[2], 32'h0);
        clearModels();
        @(posedge clk);
        #1;
        for (int a = 0; a < 48; a += 4) begin
            stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'(a), 32'h0));
        end
        applyStimulus();
        activeDut = 0;
        stimQ.push_back(mk(1, 2'b10, 0, 3'd2, 32'h08, 32'h0));
        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
